// File: rtl/mod_counter.sv
// Modulo up/down counter with wrap/saturate limits, synchronous clear/load,
// terminal pulse and sticky overflow. Define MOD_COUNTER_PRESCALE_EN to add the step prescaler.
module mod_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULUS  = 256,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             saturate,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out,
    output logic             terminal,
    output logic             overflow
);

    // Extra bit keeps MODULUS-1 and the +/-1 arithmetic exact at MODULUS = 2^WIDTH.
    localparam logic [WIDTH:0] LP_MAX = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH-1:0] r_out;
    logic             r_term;
    logic             r_ovf;

    logic             w_tick;
    logic             w_step;
    logic             w_at_limit;
    logic [WIDTH:0]   w_cur;
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_clip;

`ifdef MOD_COUNTER_PRESCALE_EN
    localparam int unsigned          LP_DIV_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [LP_DIV_W-1:0]  LP_DIV_LAST = LP_DIV_W'(PRESCALE - 1);

    logic [LP_DIV_W-1:0] r_div;

    assign w_tick = (r_div == LP_DIV_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (clear || load) begin
            r_div <= '0;
        end else if (enable) begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    assign w_step = enable & w_tick;

    always_comb begin
        w_cur      = {1'b0, r_out};
        w_at_limit = up ? (w_cur == LP_MAX) : (w_cur == '0);
        w_next     = r_out;
        if (w_at_limit) begin
            if (!saturate) begin
                w_next = up ? '0 : WIDTH'(LP_MAX);
            end
        end else begin
            w_next = up ? WIDTH'(w_cur + 1'b1) : WIDTH'(w_cur - 1'b1);
        end

        w_load_ext  = {1'b0, load_value};
        w_load_clip = (w_load_ext > LP_MAX) ? WIDTH'(LP_MAX) : load_value;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out  <= '0;
            r_term <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (clear) begin
            r_out  <= '0;
            r_term <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (load) begin
            r_out  <= w_load_clip;
            r_term <= 1'b0;
        end else begin
            r_term <= 1'b0;
            if (w_step) begin
                r_out <= w_next;
                if (w_at_limit) begin
                    r_term <= 1'b1;
                    r_ovf  <= 1'b1;
                end
            end
        end
    end

    assign out      = r_out;
    assign terminal = r_term;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: two instances (4-bit/mod-10 and 8-bit/mod-256) driven in lockstep
// against an integer reference model; honours MOD_COUNTER_PRESCALE_EN like the design.
module tb_mod_counter;

    localparam int P = 4;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       enable   = 1'b0;
    logic       up       = 1'b1;
    logic       saturate = 1'b0;
    logic       clear    = 1'b0;
    logic       load     = 1'b0;
    logic [3:0] lv_a     = '0;
    logic [7:0] lv_b     = '0;

    logic [3:0] out_a;
    logic       term_a;
    logic       ovf_a;
    logic [7:0] out_b;
    logic       term_b;
    logic       ovf_b;

    int checks = 0;
    int errors = 0;

    int modu  [2] = '{10, 256};
    int m_out [2] = '{0, 0};
    int m_term[2] = '{0, 0};
    int m_ovf [2] = '{0, 0};
    int m_cnt [2] = '{0, 0};

    always #5 clock = ~clock;

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(P)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
        .clear(clear), .load(load), .load_value(lv_a),
        .out(out_a), .terminal(term_a), .overflow(ovf_a)
    );

    mod_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(P)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
        .clear(clear), .load(load), .load_value(lv_b),
        .out(out_b), .terminal(term_b), .overflow(ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_out[i] = 0; m_term[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
        end
    endtask

    // One rising edge of the specified behaviour, using plain integer range arithmetic.
    task automatic model_edge();
        int lv, nxt;
        bit tick;
        for (int i = 0; i < 2; i++) begin
            lv = (i == 0) ? int'(lv_a) : int'(lv_b);
            if (clear) begin
                m_out[i] = 0; m_ovf[i] = 0; m_term[i] = 0; m_cnt[i] = 0;
            end else if (load) begin
                m_out[i] = (lv > modu[i] - 1) ? modu[i] - 1 : lv;
                m_term[i] = 0; m_cnt[i] = 0;
            end else begin
                m_term[i] = 0;
                if (enable) begin
`ifdef MOD_COUNTER_PRESCALE_EN
                    m_cnt[i]++;
                    tick = (m_cnt[i] == P);
                    if (tick) m_cnt[i] = 0;
`else
                    tick = 1'b1;
`endif
                    if (tick) begin
                        nxt = up ? m_out[i] + 1 : m_out[i] - 1;
                        if (nxt < 0 || nxt >= modu[i]) begin
                            m_term[i] = 1;
                            m_ovf[i]  = 1;
                            if (!saturate) m_out[i] = (nxt + modu[i]) % modu[i];
                        end else begin
                            m_out[i] = nxt;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("a_out",  out_a,  m_out[0]);
        chk("a_term", term_a, m_term[0]);
        chk("a_ovf",  ovf_a,  m_ovf[0]);
        chk("b_out",  out_b,  m_out[1]);
        chk("b_term", term_b, m_term[1]);
        chk("b_ovf",  ovf_b,  m_ovf[1]);
    endtask

    task automatic edge_step();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int guard;

        // Reset state
        #12;
        chk("rst_a_out", out_a, 0);
        chk("rst_b_out", out_b, 0);
        check_all();
        @(negedge clock);
        reset = 1'b1;

        // Up wrap at modulus 10 from 0
        enable = 1'b1; up = 1'b1; saturate = 1'b0;
        for (int i = 0; i < 11; i++) edge_step();
`ifndef MOD_COUNTER_PRESCALE_EN
        chk("wrap10_out", out_a, 1);
        chk("wrap10_ovf", ovf_a, 1);
`endif

        // Down-saturate at 0
        clear = 1'b1;
        edge_step();
        clear = 1'b0; up = 1'b0; saturate = 1'b1;
        for (int i = 0; i < 3; i++) edge_step();
`ifndef MOD_COUNTER_PRESCALE_EN
        chk("sat0_term", term_a, 1);
        chk("sat0_out",  out_a,  0);
`endif
        clear = 1'b1;
        edge_step();
        chk("clr_ovf", ovf_a, 0);

        // Load clipping and clear-over-load priority
        clear = 1'b0; enable = 1'b0; load = 1'b1; lv_a = 4'd12; lv_b = 8'd255;
        edge_step();
        chk("load_clip", out_a, 9);
        clear = 1'b1; lv_a = 4'd5;
        edge_step();
        chk("clr_over_load", out_a, 0);

        // Full-range 8-bit wrap in both directions
        clear = 1'b0; lv_b = 8'd255;
        edge_step();
        load = 1'b0; enable = 1'b1; up = 1'b1; saturate = 1'b0;
        guard = 0;
        do begin edge_step(); guard++; end while (m_term[1] == 0 && guard < 20);
        chk("b_wrap_up_out", out_b, 0);
        up = 1'b0;
        guard = 0;
        do begin edge_step(); guard++; end while (m_term[1] == 0 && guard < 20);
        chk("b_wrap_dn_out", out_b, 255);

        // Asynchronous reset mid-count
        clear = 1'b1;
        edge_step();
        clear = 1'b0; up = 1'b1;
        guard = 0;
        while (m_out[0] != 5 && guard < 40) begin edge_step(); guard++; end
        chk("count_to_5", out_a, 5);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_rst_out", out_a, 0);
        check_all();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) edge_step();

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            enable   = ($urandom_range(0, 3) != 0);
            up       = $urandom_range(0, 1);
            saturate = $urandom_range(0, 1);
            clear    = ($urandom_range(0, 29) == 0);
            load     = ($urandom_range(0, 14) == 0);
            lv_a     = 4'($urandom);
            lv_b     = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
            edge_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo up/down counter, the general-purpose successor to the fixed 4-bit free-running counter. Counts within 0..MODULUS-1 in either direction, with wrap or saturate at the limits, synchronous load and clear, a terminal-count pulse and a sticky overflow flag. An optional compiled-in prescaler slows the count rate. Used as the timing and sequencing primitive for step blocks that need more than a 4-bit free-running count.

## Interface
- WIDTH, 8: counter width in bits.
- MODULUS, 256: count range is 0..MODULUS-1; legal 2 ≤ MODULUS ≤ 2^WIDTH.
- PRESCALE, 4: enabled cycles per count step. Legal ≥ 1. Used only when the prescaler is compiled in.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- enable  in  1  count enable.
- up  in  1  direction; 1 = increment, 0 = decrement.
- saturate  in  1  limit mode; 1 = hold at limit, 0 = wrap.
- clear  in  1  synchronous clear.
- load  in  1  synchronous load.
- load_value  in  WIDTH  value to load.
- out  out  WIDTH  current count (registered).
- terminal  out  1  one-cycle pulse per step attempted at a limit.
- overflow  out  1  sticky limit-reached flag.

## Operation
- Reset (reset=0) asynchronously forces out=0, terminal=0, overflow=0 and prescaler=0. Release is used synchronously.
- Per rising edge, priority is clear > load > step.
- clear: out=0, overflow=0, terminal=0, prescaler=0.
- load: out=min(load_value, MODULUS-1), terminal=0, prescaler=0. overflow is unchanged.
- step occurs when enable=1 and tick=1. tick is always 1 without the prescaler.
- Up step: if out<MODULUS-1, out+1. At MODULUS-1, out goes to 0 (wrap) or holds (saturate).
- Down step: if out>0, out-1. At 0, out goes to MODULUS-1 (wrap) or holds (saturate).
- A step taken at a limit, in either mode, sets terminal=1 for the next cycle and sets overflow=1.
- terminal=0 in all other cycles.
- up and saturate are sampled each edge. A direction change takes effect on the next step with no extra latency.
- Arithmetic is performed in WIDTH+1 bits and must not alias when MODULUS=2^WIDTH.

## Timing
- Latency: inputs sampled at edge N are reflected on out, terminal and overflow after edge N.
- terminal is high in the same cycle that out shows the wrapped or held value.
- In saturate mode with enable held high at a limit, terminal stays high every cycle.
- With enable=0 all state holds, including the prescaler. clear and load still act.
- A reset assertion mid-count clears outputs immediately, without waiting for a clock edge.

## Configuration
- Macro: MOD_COUNTER_PRESCALE_EN.
- Defined: an internal divider of width clog2(PRESCALE), min 1 bit, counts cycles with enable=1.
  - tick=1 when divider==PRESCALE-1; the divider then returns to 0.
  - Steps occur every PRESCALE enabled cycles.
  - The divider is reset by reset, clear and load.
  - PRESCALE=1 behaves identically to the undefined case.
- Undefined: no divider logic, tick is tied to 1, and PRESCALE is ignored.

## Test plan
- WIDTH=4, MODULUS=10, up=1, saturate=0, enable high 11 cycles from 0 -> out 1..9, 0, 1; terminal high only in the cycle out=0; overflow=1 thereafter.
- out=0, up=0, saturate=1, enable high 3 cycles -> out stays 0, terminal high all 3 cycles, overflow=1; then clear -> out=0, overflow=0.
- MODULUS=10, load=1 with load_value=12 -> out=9. Next, clear=1 and load=1 together with load_value=5 -> out=0.
- Count up to 5, drive reset=0 between clock edges -> out=0, terminal=0, overflow=0 before the next edge. Release reset, then count resumes from 0.
- MOD_COUNTER_PRESCALE_EN defined, PRESCALE=4, enable high -> out increments on every 4th edge. A 2-cycle enable gap delays the next step by exactly 2 cycles. Macro undefined -> out increments every edge.
- WIDTH=8, MODULUS=256, out=255, up=1, wrap -> out=0, terminal=1. Then up=0 -> out=255, terminal=1 (no aliasing at full range).
